// File: rtl/snitch_muldiv_ipu.sv
// RV32M integer processing unit on the Snitch accelerator port. Single outstanding op.
// Define IPU_DIV_EN to build the radix-2 divider; otherwise divides report perror.
module snitch_muldiv_ipu #(
    parameter int unsigned IdWidth = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        acc_qaddr_i,
    input  logic [IdWidth-1:0] acc_qid_i,
    input  logic [31:0]        acc_qdata_op_i,
    input  logic [31:0]        acc_qdata_arga_i,
    input  logic [31:0]        acc_qdata_argb_i,
    input  logic [31:0]        acc_qdata_argc_i,
    input  logic               acc_qvalid_i,
    output logic               acc_qready_o,
    output logic [31:0]        acc_pdata_o,
    output logic [IdWidth-1:0] acc_pid_o,
    output logic               acc_perror_o,
    output logic               acc_pvalid_o,
    input  logic               acc_pready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pdata_q, pdata_d;
    logic [IdWidth-1:0] pid_q, pid_d;
    logic               perror_q, perror_d;

    logic [2:0]  funct3_s;
    logic        is_mext_s;
    logic        is_mul_s;
    logic        sign_a_s;
    logic        sign_b_s;
    logic [65:0] mul_a_s;
    logic [65:0] mul_b_s;
    logic [65:0] prod_s;
    logic        unused_s;

    assign funct3_s  = acc_qdata_op_i[14:12];
    assign is_mext_s = (acc_qdata_op_i[6:0] == 7'b0110011) && (acc_qdata_op_i[31:25] == 7'b0000001);
    assign is_mul_s  = is_mext_s && !funct3_s[2];

    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    assign sign_a_s = (funct3_s == 3'b001) || (funct3_s == 3'b010);
    assign sign_b_s = (funct3_s == 3'b001);
    assign mul_a_s  = {{34{sign_a_s & acc_qdata_arga_i[31]}}, acc_qdata_arga_i};
    assign mul_b_s  = {{34{sign_b_s & acc_qdata_argb_i[31]}}, acc_qdata_argb_i};
    assign prod_s   = mul_a_s * mul_b_s;

    assign unused_s = ^{acc_qaddr_i, acc_qdata_argc_i, acc_qdata_op_i[24:15],
                        acc_qdata_op_i[11:7], prod_s[65:64]};

`ifdef IPU_DIV_EN
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        is_rem_q, is_rem_d;
    logic        div_zero_q, div_zero_d;

    logic        is_div_s;
    logic        signed_div_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [32:0] trial_s;
    logic [31:0] rem_next_s;
    logic [31:0] quot_next_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;

    assign is_div_s     = is_mext_s && funct3_s[2];
    assign signed_div_s = !funct3_s[0];
    assign a_neg_s      = signed_div_s && acc_qdata_arga_i[31];
    assign b_neg_s      = signed_div_s && acc_qdata_argb_i[31];

    // Restoring step: quot_q shifts dividend bits out at the top and quotient bits in at the bottom.
    assign trial_s = {rem_q, quot_q[31]} - {1'b0, divisor_q};

    // Select the restored or subtracted remainder for this iteration.
    always_comb begin
        rem_next_s  = {rem_q[30:0], quot_q[31]};
        quot_next_s = {quot_q[30:0], 1'b0};
        if (!trial_s[32]) begin
            rem_next_s  = trial_s[31:0];
            quot_next_s = {quot_q[30:0], 1'b1};
        end else begin
            rem_next_s  = {rem_q[30:0], quot_q[31]};
            quot_next_s = {quot_q[30:0], 1'b0};
        end
    end

    // Divide-by-zero forces an all-ones quotient; the remainder fix-up already restores the dividend.
    assign quot_fix_s = div_zero_q ? 32'hFFFF_FFFF
                                   : (neg_quot_q ? (~quot_next_s + 32'd1) : quot_next_s);
    assign rem_fix_s  = neg_rem_q ? (~rem_next_s + 32'd1) : rem_next_s;
`endif

    // Next-state and datapath update for the IDLE/DIV/RESP sequence.
    always_comb begin
        state_d  = state_q;
        pdata_d  = pdata_q;
        pid_d    = pid_q;
        perror_d = perror_q;
`ifdef IPU_DIV_EN
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        is_rem_d   = is_rem_q;
        div_zero_d = div_zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (acc_qvalid_i) begin
                    pid_d    = acc_qid_i;
                    perror_d = 1'b0;
                    if (is_mul_s) begin
                        pdata_d = (funct3_s == 3'b000) ? prod_s[31:0] : prod_s[63:32];
                        state_d = RESP;
`ifdef IPU_DIV_EN
                    end else if (is_div_s) begin
                        cnt_d      = 5'd0;
                        rem_d      = 32'd0;
                        quot_d     = a_neg_s ? (~acc_qdata_arga_i + 32'd1) : acc_qdata_arga_i;
                        divisor_d  = b_neg_s ? (~acc_qdata_argb_i + 32'd1) : acc_qdata_argb_i;
                        neg_quot_d = a_neg_s ^ b_neg_s;
                        neg_rem_d  = a_neg_s;
                        is_rem_d   = funct3_s[1];
                        div_zero_d = (acc_qdata_argb_i == 32'd0);
                        state_d    = DIV;
`endif
                    end else begin
                        pdata_d  = 32'd0;
                        perror_d = 1'b1;
                        state_d  = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
`ifdef IPU_DIV_EN
                cnt_d  = cnt_q + 5'd1;
                rem_d  = rem_next_s;
                quot_d = quot_next_s;
                if (cnt_q == 5'd31) begin
                    pdata_d = is_rem_q ? rem_fix_s : quot_fix_s;
                    state_d = RESP;
                end else begin
                    state_d = DIV;
                end
`else
                state_d = IDLE;
`endif
            end
            RESP: begin
                if (acc_pready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset drops any in-flight operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            pdata_q  <= 32'd0;
            pid_q    <= '0;
            perror_q <= 1'b0;
`ifdef IPU_DIV_EN
            cnt_q      <= 5'd0;
            rem_q      <= 32'd0;
            quot_q     <= 32'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_rem_q   <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pdata_q  <= pdata_d;
            pid_q    <= pid_d;
            perror_q <= perror_d;
`ifdef IPU_DIV_EN
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            is_rem_q   <= is_rem_d;
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign acc_qready_o = (state_q == IDLE);
    assign acc_pvalid_o = (state_q == RESP);
    assign acc_pdata_o  = pdata_q;
    assign acc_pid_o    = pid_q;
    assign acc_perror_o = perror_q;

endmodule

// File: tb/tb_snitch_muldiv_ipu.sv
// Directed self-checking bench for snitch_muldiv_ipu; divide checks follow IPU_DIV_EN.
module tb_snitch_muldiv_ipu;

    localparam logic [31:0] OP_MUL    = 32'h0200_0033;
    localparam logic [31:0] OP_MULH   = 32'h0200_1033;
    localparam logic [31:0] OP_MULHSU = 32'h0200_2033;
    localparam logic [31:0] OP_MULHU  = 32'h0200_3033;
    localparam logic [31:0] OP_DIV    = 32'h0200_4033;
    localparam logic [31:0] OP_DIVU   = 32'h0200_5033;
    localparam logic [31:0] OP_REM    = 32'h0200_6033;
    localparam logic [31:0] OP_REMU   = 32'h0200_7033;
    localparam logic [31:0] OP_ADDI   = 32'h0000_0013;
    localparam logic [31:0] OP_ADD    = 32'h0000_0033;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] acc_qaddr_i = 32'd0;
    logic [4:0]  acc_qid_i = 5'd0;
    logic [31:0] acc_qdata_op_i = 32'd0;
    logic [31:0] acc_qdata_arga_i = 32'd0;
    logic [31:0] acc_qdata_argb_i = 32'd0;
    logic [31:0] acc_qdata_argc_i = 32'd0;
    logic        acc_qvalid_i = 1'b0;
    logic        acc_qready_o;
    logic [31:0] acc_pdata_o;
    logic [4:0]  acc_pid_o;
    logic        acc_perror_o;
    logic        acc_pvalid_o;
    logic        acc_pready_i = 1'b0;

    int checks = 0;
    int failures = 0;

    snitch_muldiv_ipu #(.IdWidth(5)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .acc_qaddr_i      (acc_qaddr_i),
        .acc_qid_i        (acc_qid_i),
        .acc_qdata_op_i   (acc_qdata_op_i),
        .acc_qdata_arga_i (acc_qdata_arga_i),
        .acc_qdata_argb_i (acc_qdata_argb_i),
        .acc_qdata_argc_i (acc_qdata_argc_i),
        .acc_qvalid_i     (acc_qvalid_i),
        .acc_qready_o     (acc_qready_o),
        .acc_pdata_o      (acc_pdata_o),
        .acc_pid_o        (acc_pid_o),
        .acc_perror_o     (acc_perror_o),
        .acc_pvalid_o     (acc_pvalid_o),
        .acc_pready_i     (acc_pready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request for a single cycle; returns sampling in the cycle after acceptance.
    task automatic issue(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] id);
        chk("qready_before_issue", {31'd0, acc_qready_o}, 32'd1);
        acc_qdata_op_i   = op;
        acc_qdata_arga_i = a;
        acc_qdata_argb_i = b;
        acc_qid_i        = id;
        acc_qaddr_i      = 32'hDEAD_BEEF;
        acc_qdata_argc_i = 32'h5555_AAAA;
        acc_qvalid_i     = 1'b1;
        step();
        acc_qvalid_i     = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] data, input logic [4:0] id,
                               input logic err);
        chk({tag, "_pvalid"}, {31'd0, acc_pvalid_o}, 32'd1);
        chk({tag, "_pdata"}, acc_pdata_o, data);
        chk({tag, "_pid"}, {27'd0, acc_pid_o}, {27'd0, id});
        chk({tag, "_perror"}, {31'd0, acc_perror_o}, {31'd0, err});
        chk({tag, "_qready_busy"}, {31'd0, acc_qready_o}, 32'd0);
    endtask

    task automatic handshake(input string tag);
        acc_pready_i = 1'b1;
        step();
        acc_pready_i = 1'b0;
        chk({tag, "_pvalid_after_hs"}, {31'd0, acc_pvalid_o}, 32'd0);
        chk({tag, "_qready_after_hs"}, {31'd0, acc_qready_o}, 32'd1);
    endtask

    task automatic mul_case(input string tag, input logic [31:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] id, input logic [31:0] exp);
        issue(op, a, b, id);
        expect_resp(tag, exp, id, 1'b0);
        handshake(tag);
    endtask

`ifdef IPU_DIV_EN
    // Response must stay low for cycles N+1..N+32 and rise exactly in N+33.
    task automatic div_case(input string tag, input logic [31:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] id, input logic [31:0] exp);
        int early;
        issue(op, a, b, id);
        early = 0;
        for (int i = 0; i < 32; i++) begin
            if (acc_pvalid_o !== 1'b0) early++;
            if (i < 31) step();
        end
        chk({tag, "_no_early_pvalid"}, early, 32'd0);
        step();
        expect_resp(tag, exp, id, 1'b0);
        handshake(tag);
    endtask
`endif

    initial begin
        step();
        chk("reset_pvalid", {31'd0, acc_pvalid_o}, 32'd0);
        chk("reset_pdata", acc_pdata_o, 32'd0);
        chk("reset_pid", {27'd0, acc_pid_o}, 32'd0);
        chk("reset_perror", {31'd0, acc_perror_o}, 32'd0);
        chk("reset_qready", {31'd0, acc_qready_o}, 32'd1);
        rst_i = 1'b0;
        step();

        mul_case("mul_7x-3", OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        // (-2^31)*(-1) = 2^31 -> high word 0
        mul_case("mulh", OP_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000);
        // (-2^31)*(2^32-1) = 0x8000_0000_8000_0000
        mul_case("mulhsu", OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000);
        // 2^31*(2^32-1) = 0x7FFF_FFFF_8000_0000
        mul_case("mulhu", OP_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h7FFF_FFFF);
        mul_case("mul_big", OP_MUL, 32'h1234_5678, 32'h0000_1000, 5'd31, 32'h4567_8000);

        issue(OP_ADDI, 32'h1, 32'h2, 5'd9);
        expect_resp("addi", 32'd0, 5'd9, 1'b1);
        handshake("addi");
        issue(OP_ADD, 32'h1, 32'h2, 5'd10);
        expect_resp("add_r", 32'd0, 5'd10, 1'b1);
        handshake("add_r");

`ifdef IPU_DIV_EN
        div_case("div_-7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4, 32'hFFFF_FFFD);
        div_case("rem_-7_2", OP_REM, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 32'hFFFF_FFFF);
        div_case("divu", OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 5'd7, 32'h0FFF_FFFF);
        div_case("div_by0", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 5'd8, 32'hFFFF_FFFF);
        div_case("remu_by0", OP_REMU, 32'h0000_1234, 32'h0000_0000, 5'd11, 32'h0000_1234);
        div_case("rem_by0_neg", OP_REM, 32'hFFFF_FFF9, 32'h0000_0000, 5'd12, 32'hFFFF_FFF9);
        div_case("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        div_case("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000);
        div_case("remu_100_7", OP_REMU, 32'h0000_0064, 32'h0000_0007, 5'd15, 32'h0000_0002);
`else
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4);
        expect_resp("div_disabled", 32'd0, 5'd4, 1'b1);
        handshake("div_disabled");
        issue(OP_REMU, 32'h0000_1234, 32'h0000_0000, 5'd11);
        expect_resp("remu_disabled", 32'd0, 5'd11, 1'b1);
        handshake("remu_disabled");
`endif

        // Backpressure: response held for 10 cycles while a new request waits.
        issue(OP_MUL, 32'h0000_0003, 32'h0000_0005, 5'd21);
        acc_qvalid_i = 1'b1;
        acc_qdata_op_i = OP_MUL;
        acc_qid_i = 5'd22;
        begin
            int unstable;
            unstable = 0;
            for (int i = 0; i < 10; i++) begin
                if (acc_pvalid_o !== 1'b1 || acc_pdata_o !== 32'd15 || acc_pid_o !== 5'd21 ||
                    acc_qready_o !== 1'b0) unstable++;
                step();
            end
            chk("bp_hold_stable", unstable, 32'd0);
        end
        acc_qvalid_i = 1'b0;
        expect_resp("bp_final", 32'd15, 5'd21, 1'b0);
        acc_qvalid_i = 1'b1;
        handshake("bp");
        acc_qvalid_i = 1'b0;

        // pready already high before the response appears.
        acc_pready_i = 1'b1;
        step();
        chk("early_pready_idle", {31'd0, acc_qready_o}, 32'd1);
        issue(OP_MUL, 32'h0000_0009, 32'h0000_0009, 5'd17);
        chk("early_pready_pvalid", {31'd0, acc_pvalid_o}, 32'd1);
        chk("early_pready_pdata", acc_pdata_o, 32'd81);
        step();
        acc_pready_i = 1'b0;
        chk("early_pready_done", {31'd0, acc_pvalid_o}, 32'd0);

        // Reset mid-operation aborts without a response.
`ifdef IPU_DIV_EN
        issue(OP_DIVU, 32'h0000_0100, 32'h0000_0003, 5'd19);
        for (int i = 0; i < 10; i++) step();
`else
        issue(OP_MUL, 32'h0000_0100, 32'h0000_0003, 5'd19);
`endif
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("abort_pvalid", {31'd0, acc_pvalid_o}, 32'd0);
        chk("abort_qready", {31'd0, acc_qready_o}, 32'd1);
        chk("abort_pdata", acc_pdata_o, 32'd0);
        begin
            int spurious;
            spurious = 0;
            for (int i = 0; i < 40; i++) begin
                if (acc_pvalid_o !== 1'b0) spurious++;
                step();
            end
            chk("abort_no_resp", spurious, 32'd0);
        end
        mul_case("post_reset_mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
